draw_ball_motion: RTL

Parametrised successor to the static ball renderer in the Arkanoid VGA chain. It sits between the background/paddle stages and the output register. It overlays a filled circle of configurable radius and colour, and moves that circle once per frame with wall reflection, paddle reflection and a lost-ball condition. It also exports the ball position so collision and scoring logic can use it.

---
 rtl/arkanoid_pkg.sv | 28 ++
 rtl/ball_motion.sv | 154 +++++++++++++++
 rtl/draw_ball_motion.sv | 121 ++++++++++++
 3 files changed

// File: rtl/arkanoid_pkg.sv
// Shared types and constants for the Arkanoid VGA drawing chain.
// Used by the ball renderer and its motion controller.
package arkanoid_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        LOST   = 2'd2
    } ball_state_t;

    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 600;
    localparam int CNT_W        = 11;
    localparam int RGB_W        = 12;

    // Magnitude of a signed distance, saturated at 1023: any radius up to 31
    // still classifies correctly and the sum of two squares cannot wrap 22 bits.
    function automatic logic [9:0] abs_sat(input logic signed [11:0] v);
        logic [11:0] mag;
        mag = v[11] ? 12'(-v) : 12'(v);
        if (mag > 12'd1023) begin
            abs_sat = 10'd1023;
        end else begin
            abs_sat = mag[9:0];
        end
    endfunction

endpackage

// File: rtl/ball_motion.sv
// Per-frame ball motion controller: frame tick detection, sticky request
// flags, IDLE/MOVING/LOST state machine and the ball position registers.
module ball_motion
    import arkanoid_pkg::*;
#(
    parameter int RADIUS   = 10,
    parameter int X_INIT   = 400,
    parameter int Y_INIT   = 500,
    parameter int SPEED    = 2,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic             pclk,
    input  logic             reset_n,
    input  logic             vblnk_in,
    input  logic             launch,
    input  logic             paddle_hit,
    output logic [CNT_W-1:0] ball_x,
    output logic [CNT_W-1:0] ball_y,
    output ball_state_t      state
);

    localparam logic signed [11:0] X_MIN_C = 12'(RADIUS);
    localparam logic signed [11:0] X_MAX_C = 12'(H_ACTIVE - 1 - RADIUS);
    localparam logic signed [11:0] Y_MIN_C = 12'(RADIUS);
    localparam logic signed [11:0] Y_MAX_C = 12'(V_ACTIVE - 1 - RADIUS);
    localparam logic signed [11:0] STEP_C  = 12'(SPEED);
    localparam logic [CNT_W-1:0]   X_INIT_C = CNT_W'(X_INIT);
    localparam logic [CNT_W-1:0]   Y_INIT_C = CNT_W'(Y_INIT);
    localparam logic [CNT_W-1:0]   STEP_U_C = CNT_W'(SPEED);

    logic              vblnk_d_r;
    logic              tick_s;
    logic              launch_flag_r;
    logic              paddle_flag_r;
    logic              launch_pend_s;
    logic              paddle_pend_s;
    ball_state_t       state_r;
    logic [CNT_W-1:0]  x_r;
    logic [CNT_W-1:0]  y_r;
    logic              dir_x_r;
    logic              dir_y_r;
    logic signed [11:0] nx_s;
    logic signed [11:0] ny_s;

    assign tick_s        = vblnk_in & ~vblnk_d_r;
    assign launch_pend_s = launch_flag_r | launch;
    assign paddle_pend_s = paddle_flag_r | paddle_hit;

    // Registered copy of vblnk for rising-edge frame tick detection.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            vblnk_d_r <= 1'b0;
        end else begin
            vblnk_d_r <= vblnk_in;
        end
    end

    // Sticky request flags; every tick consumes (or discards) both of them.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            launch_flag_r <= 1'b0;
            paddle_flag_r <= 1'b0;
        end else if (tick_s) begin
            launch_flag_r <= 1'b0;
            paddle_flag_r <= 1'b0;
        end else begin
            launch_flag_r <= launch_pend_s;
            paddle_flag_r <= paddle_pend_s;
        end
    end

    // Candidate next position, 12-bit signed so wall overshoot is visible.
    always_comb begin
        nx_s = $signed({1'b0, x_r});
        ny_s = $signed({1'b0, y_r});
        if (dir_x_r) begin
            nx_s = $signed({1'b0, x_r}) + STEP_C;
        end else begin
            nx_s = $signed({1'b0, x_r}) - STEP_C;
        end
        if (dir_y_r) begin
            ny_s = $signed({1'b0, y_r}) + STEP_C;
        end else begin
            ny_s = $signed({1'b0, y_r}) - STEP_C;
        end
    end

    // Motion state machine. Position resets to zero so the exported position
    // reads 0 under reset; IDLE reloads the parking spot on the next clock.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            x_r     <= '0;
            y_r     <= '0;
            dir_x_r <= 1'b1;
            dir_y_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    x_r     <= X_INIT_C;
                    y_r     <= Y_INIT_C;
                    dir_x_r <= 1'b1;
                    dir_y_r <= 1'b0;
                    if (tick_s && launch_pend_s) begin
                        state_r <= MOVING;
                    end
                end
                MOVING: begin
                    if (tick_s) begin
                        if (nx_s <= X_MIN_C) begin
                            x_r     <= X_MIN_C[CNT_W-1:0];
                            dir_x_r <= 1'b1;
                        end else if (nx_s >= X_MAX_C) begin
                            x_r     <= X_MAX_C[CNT_W-1:0];
                            dir_x_r <= 1'b0;
                        end else begin
                            x_r <= nx_s[CNT_W-1:0];
                        end

                        if (ny_s <= Y_MIN_C) begin
                            y_r     <= Y_MIN_C[CNT_W-1:0];
                            dir_y_r <= 1'b1;
                        end else if (paddle_pend_s) begin
                            y_r     <= y_r - STEP_U_C;
                            dir_y_r <= 1'b0;
                        end else if (ny_s >= Y_MAX_C) begin
                            state_r <= LOST;
                        end else begin
                            y_r <= ny_s[CNT_W-1:0];
                        end
                    end
                end
                LOST: begin
                    if (tick_s && launch_pend_s) begin
                        state_r <= MOVING;
                        x_r     <= X_INIT_C;
                        y_r     <= Y_INIT_C;
                        dir_x_r <= 1'b1;
                        dir_y_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ball_x = x_r;
    assign ball_y = y_r;
    assign state  = state_r;

endmodule

// File: rtl/draw_ball_motion.sv
// Moving-ball overlay for the VGA chain: a two-stage distance pipeline
// composites a filled circle over the upstream pixel stream.
module draw_ball_motion
    import arkanoid_pkg::*;
#(
    parameter int               RADIUS   = 10,
    parameter logic [RGB_W-1:0] COLOR    = 12'h0_f_0,
    parameter int               X_INIT   = 400,
    parameter int               Y_INIT   = 500,
    parameter int               SPEED    = 2,
    parameter int               H_ACTIVE = H_ACTIVE_DEF,
    parameter int               V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic             pclk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] hcount_in,
    input  logic [CNT_W-1:0] vcount_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             hblnk_in,
    input  logic             vblnk_in,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic             launch,
    input  logic             paddle_hit,
    output logic [CNT_W-1:0] hcount_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic [RGB_W-1:0] rgb_out,
    output logic [CNT_W-1:0] ball_x,
    output logic [CNT_W-1:0] ball_y,
    output logic             ball_lost
);

    localparam logic [21:0] R2_C = 22'(RADIUS * RADIUS);

    logic [CNT_W-1:0]   pos_x_s;
    logic [CNT_W-1:0]   pos_y_s;
    ball_state_t        state_s;
    logic signed [11:0] dx_s;
    logic signed [11:0] dy_s;
    logic [21:0]        dist2_s;

    logic [CNT_W-1:0] hcount_d1_r, vcount_d1_r, hcount_d2_r, vcount_d2_r;
    logic [3:0]       strobe_d1_r, strobe_d2_r;
    logic [RGB_W-1:0] rgb_d1_r, rgb_d2_r;
    logic [9:0]       adx_r, ady_r;
    logic             draw_en_r;

    ball_motion #(
        .RADIUS   (RADIUS),
        .X_INIT   (X_INIT),
        .Y_INIT   (Y_INIT),
        .SPEED    (SPEED),
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_ball_motion (
        .pclk       (pclk),
        .reset_n    (reset_n),
        .vblnk_in   (vblnk_in),
        .launch     (launch),
        .paddle_hit (paddle_hit),
        .ball_x     (pos_x_s),
        .ball_y     (pos_y_s),
        .state      (state_s)
    );

    assign dx_s    = $signed({1'b0, hcount_in}) - $signed({1'b0, pos_x_s});
    assign dy_s    = $signed({1'b0, vcount_in}) - $signed({1'b0, pos_y_s});
    assign dist2_s = 22'(adx_r) * 22'(adx_r) + 22'(ady_r) * 22'(ady_r);

    // Stage 1: delay timing, take distance magnitudes, qualify drawing.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_d1_r <= '0;
            vcount_d1_r <= '0;
            strobe_d1_r <= '0;
            rgb_d1_r    <= '0;
            adx_r       <= '0;
            ady_r       <= '0;
            draw_en_r   <= 1'b0;
        end else begin
            hcount_d1_r <= hcount_in;
            vcount_d1_r <= vcount_in;
            strobe_d1_r <= {hsync_in, vsync_in, hblnk_in, vblnk_in};
            rgb_d1_r    <= rgb_in;
            adx_r       <= abs_sat(dx_s);
            ady_r       <= abs_sat(dy_s);
            draw_en_r   <= ~hblnk_in & ~vblnk_in & (state_s != LOST);
        end
    end

    // Stage 2: circle test and pixel select into the output registers.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_d2_r <= '0;
            vcount_d2_r <= '0;
            strobe_d2_r <= '0;
            rgb_d2_r    <= '0;
        end else begin
            hcount_d2_r <= hcount_d1_r;
            vcount_d2_r <= vcount_d1_r;
            strobe_d2_r <= strobe_d1_r;
            rgb_d2_r    <= (draw_en_r && (dist2_s <= R2_C)) ? COLOR : rgb_d1_r;
        end
    end

    assign hcount_out = hcount_d2_r;
    assign vcount_out = vcount_d2_r;
    assign hsync_out  = strobe_d2_r[3];
    assign vsync_out  = strobe_d2_r[2];
    assign hblnk_out  = strobe_d2_r[1];
    assign vblnk_out  = strobe_d2_r[0];
    assign rgb_out    = rgb_d2_r;
    assign ball_x     = pos_x_s;
    assign ball_y     = pos_y_s;
    assign ball_lost  = (state_s == LOST);

endmodule
